// File: rtl/starflux_pkg.sv
// Shared defaults, state encoding and sizing helper for the bullet-grid front end.
package starflux_pkg;

    localparam int DEF_ROWS = 120;
    localparam int DEF_X_W  = 8;

    typedef enum logic [1:0] {
        READY    = 2'd0,
        COOLDOWN = 2'd1,
        RELOAD   = 2'd2
    } state_t;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/shot_spawner_tick_gen.sv
// Free-running down-counter that strobes tick while the count is zero, then reloads.
module tick_gen
    import starflux_pkg::*;
#(
    parameter int COUNT = 49_999_999
) (
    input  logic clock,
    input  logic reset_n,
    output logic tick
);

    localparam int             W         = cnt_width(COUNT);
    localparam logic [W-1:0]   START_VAL = W'(COUNT);
    localparam logic [W-1:0]   ONE       = W'(1'b1);

    logic [W-1:0] count_r;

    assign tick = (count_r == {W{1'b0}});

    // Count down to zero and reload, giving a period of COUNT+1 cycles.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= START_VAL;
        end else if (tick) begin
            count_r <= START_VAL;
        end else begin
            count_r <= count_r - ONE;
        end
    end

endmodule

// File: rtl/shot_spawner.sv
// Conditions the shoot switch, paces shots with cooldown and magazine reload, and
// emits the shift tick plus a one-hot fire row aligned with that tick.
module shot_spawner
    import starflux_pkg::*;
#(
    parameter int ROWS           = DEF_ROWS,
    parameter int X_W            = DEF_X_W,
    parameter int TICK_COUNT     = 49_999_999,
    parameter int COOLDOWN_TICKS = 4,
    parameter int MAG_SIZE       = 8,
    parameter int RELOAD_TICKS   = 16
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            shoot,
    input  logic [X_W-1:0]  player_x,
    output logic            tick,
    output logic            fire,
    output logic [ROWS-1:0] fire_row,
    output logic [3:0]      ammo,
    output logic            reloading
);

    localparam int               CD_W    = cnt_width(COOLDOWN_TICKS);
    localparam int               RL_W    = cnt_width(RELOAD_TICKS);
    localparam logic [CD_W-1:0]  CD_INIT = CD_W'(COOLDOWN_TICKS);
    localparam logic [CD_W-1:0]  CD_ONE  = CD_W'(1'b1);
    localparam logic [RL_W-1:0]  RL_INIT = RL_W'(RELOAD_TICKS);
    localparam logic [RL_W-1:0]  RL_ONE  = RL_W'(1'b1);
    localparam logic [3:0]       MAG     = 4'(MAG_SIZE);
    localparam logic [31:0]      ROWS_U  = 32'(ROWS);

    logic            tick_raw_s;
    logic            sync1_r;
    logic            sync2_r;
    logic            prev_r;
    logic            edge_s;
    logic            x_bad_s;
    logic [ROWS-1:0] onehot_s;
    logic            pending_r;
    state_t          state_r;
    logic [CD_W-1:0] cd_cnt_r;
    logic [RL_W-1:0] rl_cnt_r;

    tick_gen #(
        .COUNT (TICK_COUNT)
    ) u_tick_gen (
        .clock   (clock),
        .reset_n (reset_n),
        .tick    (tick_raw_s)
    );

    assign edge_s   = sync2_r & ~prev_r;
    assign x_bad_s  = (32'(player_x) >= ROWS_U);
    assign onehot_s = {{(ROWS-1){1'b0}}, 1'b1} << player_x;

    // Two-flop synchroniser on the raw switch plus a delay flop for edge detection.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= shoot;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Shot pacing FSM; all outputs are registered so fire stays aligned with tick.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= READY;
            pending_r <= 1'b0;
            cd_cnt_r  <= {CD_W{1'b0}};
            rl_cnt_r  <= {RL_W{1'b0}};
            ammo      <= MAG;
            reloading <= 1'b0;
            tick      <= 1'b0;
            fire      <= 1'b0;
            fire_row  <= {ROWS{1'b0}};
        end else begin
            tick     <= tick_raw_s;
            fire     <= 1'b0;
            fire_row <= {ROWS{1'b0}};
            case (state_r)
                READY: begin
                    if (tick_raw_s && (pending_r || edge_s)) begin
                        pending_r <= 1'b0;
                        // An off-grid position swallows the request without spending ammo.
                        if (!x_bad_s && (ammo != 4'd0)) begin
                            fire     <= 1'b1;
                            fire_row <= onehot_s;
                            ammo     <= ammo - 4'd1;
                            if (COOLDOWN_TICKS == 0) begin
                                if (ammo > 4'd1) begin
                                    state_r <= READY;
                                end else begin
                                    state_r   <= RELOAD;
                                    rl_cnt_r  <= RL_INIT;
                                    reloading <= 1'b1;
                                end
                            end else begin
                                state_r  <= COOLDOWN;
                                cd_cnt_r <= CD_INIT;
                            end
                        end else begin
                            state_r <= READY;
                        end
                    end else if (edge_s) begin
                        pending_r <= 1'b1;
                    end else begin
                        pending_r <= pending_r;
                    end
                end
                COOLDOWN: begin
                    pending_r <= 1'b0;
                    if (tick_raw_s) begin
                        if (cd_cnt_r <= CD_ONE) begin
                            if (ammo != 4'd0) begin
                                state_r <= READY;
                            end else begin
                                state_r   <= RELOAD;
                                rl_cnt_r  <= RL_INIT;
                                reloading <= 1'b1;
                            end
                        end else begin
                            cd_cnt_r <= cd_cnt_r - CD_ONE;
                        end
                    end
                end
                RELOAD: begin
                    pending_r <= 1'b0;
                    if (tick_raw_s) begin
                        if (rl_cnt_r <= RL_ONE) begin
                            ammo      <= MAG;
                            reloading <= 1'b0;
                            state_r   <= READY;
                        end else begin
                            rl_cnt_r <= rl_cnt_r - RL_ONE;
                        end
                    end
                end
                default: begin
                    state_r   <= READY;
                    pending_r <= 1'b0;
                    reloading <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shot_spawner.sv
// Directed scoreboard bench for shot_spawner: stimulus queues the expected per-tick
// outputs, a negedge monitor pops and compares whenever the DUT presents a tick.
module tb_shot_spawner;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       shoot;
    logic [7:0] player_x;
    logic       tick;
    logic       fire;
    logic [7:0] fire_row;
    logic [3:0] ammo;
    logic       reloading;

    typedef struct packed {
        logic       fire;
        logic [7:0] row;
        logic [3:0] ammo;
        logic       rel;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    shot_spawner #(
        .ROWS           (8),
        .X_W            (8),
        .TICK_COUNT     (3),
        .COOLDOWN_TICKS (2),
        .MAG_SIZE       (2),
        .RELOAD_TICKS   (3)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .shoot     (shoot),
        .player_x  (player_x),
        .tick      (tick),
        .fire      (fire),
        .fire_row  (fire_row),
        .ammo      (ammo),
        .reloading (reloading)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // One tick period: queue the expected tick outputs, drive shoot per cycle from pat.
    task automatic step(input logic [3:0] pat, input logic efire, input logic [7:0] erow,
                        input logic [3:0] eammo, input logic erel);
        exp_t e;
        e.fire = efire;
        e.row  = erow;
        e.ammo = eammo;
        e.rel  = erel;
        exp_q.push_back(e);
        for (int i = 0; i < 4; i++) begin
            shoot = pat[i];
            @(posedge clock);
            #1;
            check("tick_phase", {31'd0, tick}, {31'd0, (i == 3)});
        end
    endtask

    // Monitor: idle-cycle invariants, and scoreboard compare on every tick.
    always @(negedge clock) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (tick !== 1'b1) begin
                check("fire_without_tick", {31'd0, fire}, 32'd0);
                check("row_idle", {24'd0, fire_row}, 32'd0);
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_tick: got tick=1 expected no tick at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("fire", {31'd0, fire}, {31'd0, e.fire});
                check("fire_row", {24'd0, fire_row}, {24'd0, e.row});
                check("ammo", {28'd0, ammo}, {28'd0, e.ammo});
                check("reloading", {31'd0, reloading}, {31'd0, e.rel});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        shoot    = 1'b0;
        player_x = 8'd0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_fire", {31'd0, fire}, 32'd0);
        check("rst_row", {24'd0, fire_row}, 32'd0);
        check("rst_ammo", {28'd0, ammo}, 32'd2);
        check("rst_reloading", {31'd0, reloading}, 32'd0);
        reset_n = 1'b1;

        // Idle: tick every 4 cycles, nothing fires.
        repeat (5) step(4'b0000, 1'b0, 8'h00, 4'd2, 1'b0);

        // Single pulse between ticks, then an ignored pulse during cooldown.
        player_x = 8'd5;
        step(4'b0011, 1'b1, 8'h20, 4'd1, 1'b0);
        step(4'b0011, 1'b0, 8'h00, 4'd1, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);

        // Held switch: one shot, empties the magazine, reloads, never re-fires.
        step(4'b1111, 1'b1, 8'h20, 4'd0, 1'b0);
        step(4'b1111, 1'b0, 8'h00, 4'd0, 1'b0);
        step(4'b1111, 1'b0, 8'h00, 4'd0, 1'b1);
        step(4'b1111, 1'b0, 8'h00, 4'd0, 1'b1);
        step(4'b1111, 1'b0, 8'h00, 4'd0, 1'b1);
        step(4'b1111, 1'b0, 8'h00, 4'd2, 1'b0);
        repeat (4) step(4'b1111, 1'b0, 8'h00, 4'd2, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd2, 1'b0);
        player_x = 8'd2;
        step(4'b0011, 1'b1, 8'h04, 4'd1, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);

        // Edge coincident with tick fires on that tick; magazine empties and reloads.
        player_x = 8'd7;
        step(4'b0110, 1'b1, 8'h80, 4'd0, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd0, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd0, 1'b1);
        step(4'b0011, 1'b0, 8'h00, 4'd0, 1'b1);
        step(4'b0000, 1'b0, 8'h00, 4'd0, 1'b1);
        step(4'b0000, 1'b0, 8'h00, 4'd2, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd2, 1'b0);

        // Edge just after a tick is held pending until the next tick.
        player_x = 8'd1;
        step(4'b1100, 1'b0, 8'h00, 4'd2, 1'b0);
        step(4'b0000, 1'b1, 8'h02, 4'd1, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);

        // Off-grid position: no shot, ammo kept, pending dropped, still READY.
        player_x = 8'd9;
        step(4'b0011, 1'b0, 8'h00, 4'd1, 1'b0);
        step(4'b1100, 1'b0, 8'h00, 4'd1, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);
        player_x = 8'd3;
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);
        step(4'b0011, 1'b1, 8'h08, 4'd0, 1'b0);

        // Reset in the middle of cooldown with the switch active.
        step(4'b0011, 1'b0, 8'h00, 4'd0, 1'b0);
        shoot = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_tick", {31'd0, tick}, 32'd0);
        check("async_fire", {31'd0, fire}, 32'd0);
        check("async_row", {24'd0, fire_row}, 32'd0);
        check("async_ammo", {28'd0, ammo}, 32'd2);
        check("async_reloading", {31'd0, reloading}, 32'd0);
        shoot = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(4'b0000, 1'b0, 8'h00, 4'd2, 1'b0);
        player_x = 8'd4;
        step(4'b0011, 1'b1, 8'h10, 4'd1, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);
        step(4'b0000, 1'b0, 8'h00, 4'd1, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        check("queue_drain", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
